uc_movimenta_asteroides_tiros: RTL and testbench
================================================

Name: uc_movimenta_asteroides_tiros

Overview:
Movement and collision engine for asteroids and shots. It is started by the main game control unit's inicia_movimentacao_asteroides_e_tiros level and answers with a one-cycle fim pulse. It holds the asteroid and shot tables: each entry has a valid bit, a 3-bit direction (8 lanes around the ship) and a distance from the ship. One round moves every asteroid inward and every shot outward, then resolves shot/asteroid hits and ship hits.

Parameters:
N_AST, 4, number of asteroid slots
N_TIROS, 4, number of shot slots
DIST_W, 4, distance width; DMAX = 2^DIST_W-1 (15)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high; clears tables and FSM
iniciar  in  1  start a round; sampled only in OCIOSO
novo_asteroide  in  1  insert-asteroid request; sampled only in OCIOSO
direcao_asteroide  in  3  lane of the new asteroid
novo_tiro  in  1  insert-shot request; sampled only in OCIOSO
direcao_tiro  in  3  lane of the new shot
fim_movimentacao  out  1  one-cycle pulse at end of round
perdeu_vida  out  1  one-cycle pulse per asteroid reaching ship
acerto  out  1  one-cycle pulse per shot/asteroid hit
asteroide_ack  out  1  one-cycle pulse: asteroid inserted
tiro_ack  out  1  one-cycle pulse: shot inserted
asteroides_cheio  out  1  no free asteroid slot (combinational from valid bits)
tiros_cheio  out  1  no free shot slot
asteroides_validos  out  N_AST  valid bits, slot i at bit i
asteroides_dist  out  N_AST*DIST_W  distances, slot i at [i*DIST_W +: DIST_W]
asteroides_dir  out  N_AST*3  lanes, slot i at [i*3 +: 3]
tiros_validos / tiros_dist / tiros_dir  out  N_TIROS, N_TIROS*DIST_W, N_TIROS*3  same layout for shots
db_estado  out  3  0 OCIOSO, 1 MOVE_AST, 2 MOVE_TIRO, 3 COLISAO, 4 FIM

Behaviour:
- Reset (synchronous, takes priority in any state): all valid bits 0, dist/dir 0, state OCIOSO, index counters 0.
- All pulse outputs are 0 after reset. Outputs are registered unless noted.
- A reset in mid-round aborts the round with no fim pulse.
- OCIOSO:
  - novo_asteroide=1 and not cheio: write the lowest-index free slot with dir=direcao_asteroide, dist=DMAX, valid=1. asteroide_ack=1 next cycle.
  - If the table is full, the request is dropped and asteroide_ack stays 0.
  - novo_tiro works the same way, with dist=1 and tiro_ack.
  - Both inserts may occur in the same cycle.
  - iniciar=1: go to MOVE_AST with i=0. An insert in that same cycle is still performed and is moved in this round.
- Requests in any state other than OCIOSO are ignored; no ack is given.
- MOVE_AST, one slot per cycle, i=0..N_AST-1:
  - If valid and dist==1: clear valid and pulse perdeu_vida.
  - Else if valid: dist-1.
  - Invalid slots are untouched.
  - After i=N_AST-1, go to MOVE_TIRO with j=0.
- MOVE_TIRO, one slot per cycle, j=0..N_TIROS-1:
  - If valid and dist==DMAX: clear valid (shot leaves the field).
  - Else if valid: dist+1.
  - Then go to COLISAO.
- COLISAO, one pair per cycle, i outer 0..N_AST-1, j inner 0..N_TIROS-1:
  - Hit when ast[i] valid, tiro[j] valid, same dir, and tiro.dist >= ast.dist.
  - On a hit, clear both valid bits and pulse acerto.
  - A freed entry is seen as invalid by every later pair, so one shot kills at most one asteroid.
  - After the last pair, go to FIM.
- FIM: fim_movimentacao=1 for exactly this cycle, then OCIOSO.
  - If iniciar is still high, the next round starts on the following OCIOSO cycle.
  - The upstream FSM leaves espera_jogada before that happens.
- Round length: N_AST + N_TIROS + N_AST*N_TIROS + 1 cycles after the OCIOSO cycle that sampled iniciar. With defaults this is 25, with fim in the 25th cycle.
- Distance arithmetic is unsigned DIST_W bits. No wrap is possible: a decrement only happens from dist>=2, and an increment only from dist<DMAX.
- A slot freed in a round is reusable in the next OCIOSO cycle.

Test Plan:
1. Reset, then idle 10 cycles -> all validos=0, cheio=0, fim/acks=0, db_estado=0 throughout.
2. novo_asteroide dir=3, next cycle iniciar pulse -> asteroide_ack one cycle; fim exactly 25 cycles after iniciar sampled; slot0 dist=14, dir=3.
3. One asteroid, 15 rounds -> dist 15→1 over 14 rounds. Round 15: perdeu_vida pulse in the MOVE_AST cycle of slot 0, valid0=0. No further pulses in round 16.
4. Asteroid dir=5 plus shot dir=5, inserted together, then rounds -> after round 7 ast dist=8, tiro dist=8. acerto pulses once in COLISAO of round 7 and both valid=0. Repeat with shot dir=4 -> no acerto; shot freed in round 15 (dist reached 15 in round 14).
5. Five novo_asteroide requests on separate OCIOSO cycles -> first four acked (slots 0,1,2,3), asteroides_cheio=1, fifth gets no ack and no table change. Free slot 1 via a hit -> next insert goes to slot 1.
6. Pulse novo_tiro during MOVE_TIRO -> ignored. Assert reset in COLISAO -> next cycle db_estado=0, all tables cleared, no fim pulse.

Source files
------------

// File: rtl/uc_movimenta_asteroides_tiros.sv
// uc_movimenta_asteroides_tiros: asteroid/shot tables with a round FSM that moves every entry and resolves hits.
module uc_movimenta_asteroides_tiros #(
    parameter int N_AST   = 4,
    parameter int N_TIROS = 4,
    parameter int DIST_W  = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        iniciar,
    input  logic                        novo_asteroide,
    input  logic [2:0]                  direcao_asteroide,
    input  logic                        novo_tiro,
    input  logic [2:0]                  direcao_tiro,
    output logic                        fim_movimentacao,
    output logic                        perdeu_vida,
    output logic                        acerto,
    output logic                        asteroide_ack,
    output logic                        tiro_ack,
    output logic                        asteroides_cheio,
    output logic                        tiros_cheio,
    output logic [N_AST-1:0]            asteroides_validos,
    output logic [N_AST*DIST_W-1:0]     asteroides_dist,
    output logic [N_AST*3-1:0]          asteroides_dir,
    output logic [N_TIROS-1:0]          tiros_validos,
    output logic [N_TIROS*DIST_W-1:0]   tiros_dist,
    output logic [N_TIROS*3-1:0]        tiros_dir,
    output logic [2:0]                  db_estado
);
    localparam int IA = N_AST > 1 ? $clog2(N_AST) : 1;
    localparam int IT = N_TIROS > 1 ? $clog2(N_TIROS) : 1;
    localparam logic [DIST_W-1:0] DMAX = '1;
    localparam logic [DIST_W-1:0] ONE = DIST_W'(1);
    localparam logic [IA-1:0] I_LAST = IA'(N_AST - 1);
    localparam logic [IT-1:0] J_LAST = IT'(N_TIROS - 1);

    typedef enum logic [2:0] {OCIOSO = 3'd0, MOVE_AST = 3'd1, MOVE_TIRO = 3'd2, COLISAO = 3'd3, FIM = 3'd4} estado_t;

    estado_t estado_q, estado_d;
    logic [IA-1:0] i_q, i_d, ast_livre;
    logic [IT-1:0] j_q, j_d, tiro_livre;
    logic ast_v_q [N_AST];
    logic ast_v_d [N_AST];
    logic [DIST_W-1:0] ast_dist_q [N_AST];
    logic [DIST_W-1:0] ast_dist_d [N_AST];
    logic [2:0] ast_dir_q [N_AST];
    logic [2:0] ast_dir_d [N_AST];
    logic tiro_v_q [N_TIROS];
    logic tiro_v_d [N_TIROS];
    logic [DIST_W-1:0] tiro_dist_q [N_TIROS];
    logic [DIST_W-1:0] tiro_dist_d [N_TIROS];
    logic [2:0] tiro_dir_q [N_TIROS];
    logic [2:0] tiro_dir_d [N_TIROS];
    logic fim_q, fim_d, perdeu_q, perdeu_d, acerto_q, acerto_d;
    logic ast_ack_q, ast_ack_d, tiro_ack_q, tiro_ack_d;
    logic hit;

    for (genvar g = 0; g < N_AST; g++) begin : g_ast
        assign asteroides_validos[g] = ast_v_q[g];
        assign asteroides_dist[g*DIST_W +: DIST_W] = ast_dist_q[g];
        assign asteroides_dir[g*3 +: 3] = ast_dir_q[g];
    end
    for (genvar g = 0; g < N_TIROS; g++) begin : g_tiro
        assign tiros_validos[g] = tiro_v_q[g];
        assign tiros_dist[g*DIST_W +: DIST_W] = tiro_dist_q[g];
        assign tiros_dir[g*3 +: 3] = tiro_dir_q[g];
    end

    assign asteroides_cheio = &asteroides_validos;
    assign tiros_cheio      = &tiros_validos;
    assign fim_movimentacao = fim_q;
    assign perdeu_vida      = perdeu_q;
    assign acerto           = acerto_q;
    assign asteroide_ack    = ast_ack_q;
    assign tiro_ack         = tiro_ack_q;
    assign db_estado        = estado_q;
    assign hit = ast_v_q[i_q] && tiro_v_q[j_q] && ast_dir_q[i_q] == tiro_dir_q[j_q]
                 && tiro_dist_q[j_q] >= ast_dist_q[i_q];

    // descending scan leaves the lowest free index
    always_comb begin
        ast_livre  = '0;
        tiro_livre = '0;
        for (int k = N_AST - 1; k >= 0; k--) if (!ast_v_q[k]) ast_livre = IA'(k);
        for (int k = N_TIROS - 1; k >= 0; k--) if (!tiro_v_q[k]) tiro_livre = IT'(k);
    end

    always_comb begin
        estado_d    = estado_q;
        i_d         = i_q;
        j_d         = j_q;
        ast_v_d     = ast_v_q;
        ast_dist_d  = ast_dist_q;
        ast_dir_d   = ast_dir_q;
        tiro_v_d    = tiro_v_q;
        tiro_dist_d = tiro_dist_q;
        tiro_dir_d  = tiro_dir_q;
        fim_d       = 1'b0;
        perdeu_d    = 1'b0;
        acerto_d    = 1'b0;
        ast_ack_d   = 1'b0;
        tiro_ack_d  = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (novo_asteroide && !asteroides_cheio) begin
                    ast_v_d[ast_livre]    = 1'b1;
                    ast_dist_d[ast_livre] = DMAX;
                    ast_dir_d[ast_livre]  = direcao_asteroide;
                    ast_ack_d             = 1'b1;
                end
                if (novo_tiro && !tiros_cheio) begin
                    tiro_v_d[tiro_livre]    = 1'b1;
                    tiro_dist_d[tiro_livre] = ONE;
                    tiro_dir_d[tiro_livre]  = direcao_tiro;
                    tiro_ack_d              = 1'b1;
                end
                if (iniciar) begin
                    estado_d = MOVE_AST;
                    i_d      = '0;
                end
            end
            MOVE_AST: begin
                if (ast_v_q[i_q] && ast_dist_q[i_q] == ONE) begin
                    ast_v_d[i_q] = 1'b0;
                    perdeu_d     = 1'b1;
                end else if (ast_v_q[i_q]) ast_dist_d[i_q] = ast_dist_q[i_q] - ONE;
                i_d = i_q == I_LAST ? '0 : i_q + IA'(1);
                if (i_q == I_LAST) begin
                    estado_d = MOVE_TIRO;
                    j_d      = '0;
                end
            end
            MOVE_TIRO: begin
                if (tiro_v_q[j_q] && tiro_dist_q[j_q] == DMAX) tiro_v_d[j_q] = 1'b0;
                else if (tiro_v_q[j_q]) tiro_dist_d[j_q] = tiro_dist_q[j_q] + ONE;
                j_d = j_q == J_LAST ? '0 : j_q + IT'(1);
                if (j_q == J_LAST) begin
                    estado_d = COLISAO;
                    i_d      = '0;
                end
            end
            COLISAO: begin
                if (hit) begin
                    ast_v_d[i_q]  = 1'b0;
                    tiro_v_d[j_q] = 1'b0;
                    acerto_d      = 1'b1;
                end
                j_d = j_q == J_LAST ? '0 : j_q + IT'(1);
                if (j_q == J_LAST) i_d = i_q == I_LAST ? '0 : i_q + IA'(1);
                if (j_q == J_LAST && i_q == I_LAST) begin
                    estado_d = FIM;
                    fim_d    = 1'b1;
                end
            end
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            i_q        <= '0;
            j_q        <= '0;
            fim_q      <= 1'b0;
            perdeu_q   <= 1'b0;
            acerto_q   <= 1'b0;
            ast_ack_q  <= 1'b0;
            tiro_ack_q <= 1'b0;
            for (int k = 0; k < N_AST; k++) begin
                ast_v_q[k]    <= 1'b0;
                ast_dist_q[k] <= '0;
                ast_dir_q[k]  <= '0;
            end
            for (int k = 0; k < N_TIROS; k++) begin
                tiro_v_q[k]    <= 1'b0;
                tiro_dist_q[k] <= '0;
                tiro_dir_q[k]  <= '0;
            end
        end else begin
            estado_q    <= estado_d;
            i_q         <= i_d;
            j_q         <= j_d;
            fim_q       <= fim_d;
            perdeu_q    <= perdeu_d;
            acerto_q    <= acerto_d;
            ast_ack_q   <= ast_ack_d;
            tiro_ack_q  <= tiro_ack_d;
            ast_v_q     <= ast_v_d;
            ast_dist_q  <= ast_dist_d;
            ast_dir_q   <= ast_dir_d;
            tiro_v_q    <= tiro_v_d;
            tiro_dist_q <= tiro_dist_d;
            tiro_dir_q  <= tiro_dir_d;
        end
    end
endmodule

// File: tb/tb_uc_movimenta_asteroides_tiros.sv
// tb_uc_movimenta_asteroides_tiros: scoreboard bench with an array-based game model.
module tb_uc_movimenta_asteroides_tiros;
    logic clock = 1'b0, reset = 1'b1, iniciar = 1'b0, novo_asteroide = 1'b0, novo_tiro = 1'b0;
    logic [2:0] direcao_asteroide = '0, direcao_tiro = '0;
    logic fim_movimentacao, perdeu_vida, acerto, asteroide_ack, tiro_ack, asteroides_cheio, tiros_cheio;
    logic [3:0] asteroides_validos, tiros_validos;
    logic [15:0] asteroides_dist, tiros_dist;
    logic [11:0] asteroides_dir, tiros_dir;
    logic [2:0] db_estado;

    uc_movimenta_asteroides_tiros dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .novo_asteroide(novo_asteroide), .direcao_asteroide(direcao_asteroide),
        .novo_tiro(novo_tiro), .direcao_tiro(direcao_tiro),
        .fim_movimentacao(fim_movimentacao), .perdeu_vida(perdeu_vida), .acerto(acerto),
        .asteroide_ack(asteroide_ack), .tiro_ack(tiro_ack),
        .asteroides_cheio(asteroides_cheio), .tiros_cheio(tiros_cheio),
        .asteroides_validos(asteroides_validos), .asteroides_dist(asteroides_dist),
        .asteroides_dir(asteroides_dir), .tiros_validos(tiros_validos),
        .tiros_dist(tiros_dist), .tiros_dir(tiros_dir), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0, failures = 0;

    typedef struct { int cyc; bit a; bit t; } ack_t;
    typedef struct {
        int fim_cyc; int np; int nh;
        logic [3:0] av; logic [15:0] ad; logic [11:0] adr;
        logic [3:0] tv; logic [15:0] td; logic [11:0] tdr;
    } rnd_t;
    ack_t ack_q[$];
    rnd_t rnd_q[$];

    bit mav[4], mtv[4];
    int mad[4], madr[4], mtd[4], mtdr[4];

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            mav[i] = 0; mtv[i] = 0;
        end
    endtask

    task automatic model_round(output int np, output int nh);
        np = 0;
        nh = 0;
        for (int i = 0; i < 4; i++)
            if (mav[i]) begin
                if (mad[i] == 1) begin mav[i] = 0; np++; end
                else mad[i]--;
            end
        for (int j = 0; j < 4; j++)
            if (mtv[j]) begin
                if (mtd[j] == 15) mtv[j] = 0;
                else mtd[j]++;
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (mav[i] && mtv[j] && madr[i] == mtdr[j] && mtd[j] >= mad[i]) begin
                    mav[i] = 0; mtv[j] = 0; nh++;
                end
    endtask

    task automatic push_round(int s);
        rnd_t r;
        model_round(r.np, r.nh);
        r.fim_cyc = s + 24;
        for (int i = 0; i < 4; i++) begin
            r.av[i] = mav[i]; r.ad[i*4 +: 4] = 4'(mad[i]); r.adr[i*3 +: 3] = 3'(madr[i]);
            r.tv[i] = mtv[i]; r.td[i*4 +: 4] = 4'(mtd[i]); r.tdr[i*3 +: 3] = 3'(mtdr[i]);
        end
        rnd_q.push_back(r);
    endtask

    // one OCIOSO cycle of requests; with ini the whole round is waited out
    task automatic cycle_in(bit na, int da, bit nt, int dt, bit ini);
        int s;
        ack_t a;
        s = cyc + 1;
        novo_asteroide = na; direcao_asteroide = 3'(da);
        novo_tiro = nt; direcao_tiro = 3'(dt); iniciar = ini;
        if (na || nt) begin
            a.cyc = s; a.a = 0; a.t = 0;
            if (na) for (int i = 0; i < 4; i++) if (!mav[i]) begin
                mav[i] = 1; mad[i] = 15; madr[i] = da; a.a = 1; break;
            end
            if (nt) for (int j = 0; j < 4; j++) if (!mtv[j]) begin
                mtv[j] = 1; mtd[j] = 1; mtdr[j] = dt; a.t = 1; break;
            end
            ack_q.push_back(a);
        end
        if (ini) push_round(s);
        step();
        novo_asteroide = 0; novo_tiro = 0; iniciar = 0;
        if (ini) repeat (25) step();
    endtask

    task automatic run_round();
        cycle_in(0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        step();
        reset = 0;
        model_clear();
    endtask

    // round with requests injected mid-round, or aborted by reset in COLISAO
    task automatic round_special(bit abort);
        int s;
        s = cyc + 1;
        if (!abort) push_round(s);
        iniciar = 1;
        step();
        iniciar = 0;
        repeat (4) step();
        if (!abort) begin
            novo_tiro = 1; novo_asteroide = 1; direcao_tiro = 3'd2; direcao_asteroide = 3'd2;
            step();
            novo_tiro = 0; novo_asteroide = 0;
            repeat (20) step();
        end else begin
            repeat (6) step();
            reset = 1;
            step();
            reset = 0;
            model_clear();
            chk("abort_estado", db_estado, 0);
            chk("abort_ast_validos", asteroides_validos, 0);
            chk("abort_tiros_validos", tiros_validos, 0);
            chk("abort_ast_dist", asteroides_dist, 0);
            chk("abort_tiros_dist", tiros_dist, 0);
            chk("abort_ast_dir", asteroides_dir, 0);
            chk("abort_tiros_dir", tiros_dir, 0);
            repeat (30) step();
        end
    endtask

    int np_seen = 0, nh_seen = 0;

    initial forever begin
        @(negedge clock);
        if (reset) begin
            np_seen = 0;
            nh_seen = 0;
        end else begin
            np_seen += int'(perdeu_vida);
            nh_seen += int'(acerto);
            if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
                ack_t a;
                a = ack_q.pop_front();
                chk("asteroide_ack", asteroide_ack, a.a);
                chk("tiro_ack", tiro_ack, a.t);
            end else if (asteroide_ack || tiro_ack) begin
                chk("spurious_ack", int'(asteroide_ack) + int'(tiro_ack), 0);
            end
            if (fim_movimentacao) begin
                if (rnd_q.size() == 0) chk("spurious_fim", 1, 0);
                else begin
                    rnd_t r;
                    r = rnd_q.pop_front();
                    chk("fim_cycle", cyc, r.fim_cyc);
                    chk("fim_estado", db_estado, 4);
                    chk("perdeu_count", np_seen, r.np);
                    chk("acerto_count", nh_seen, r.nh);
                    chk("ast_validos", asteroides_validos, r.av);
                    chk("tiros_validos", tiros_validos, r.tv);
                    chk("ast_cheio", asteroides_cheio, &r.av);
                    chk("tiros_cheio", tiros_cheio, &r.tv);
                    for (int i = 0; i < 4; i++) begin
                        if (r.av[i]) begin
                            chk($sformatf("ast%0d_dist", i), asteroides_dist[i*4 +: 4], r.ad[i*4 +: 4]);
                            chk($sformatf("ast%0d_dir", i), asteroides_dir[i*3 +: 3], r.adr[i*3 +: 3]);
                        end
                        if (r.tv[i]) begin
                            chk($sformatf("tiro%0d_dist", i), tiros_dist[i*4 +: 4], r.td[i*4 +: 4]);
                            chk($sformatf("tiro%0d_dir", i), tiros_dir[i*3 +: 3], r.tdr[i*3 +: 3]);
                        end
                    end
                end
                np_seen = 0;
                nh_seen = 0;
            end
        end
    end

    initial begin
        model_clear();
        repeat (3) step();
        reset = 0;
        repeat (10) begin
            cycle_in(0, 0, 0, 0, 0);
            chk("idle_estado", db_estado, 0);
            chk("idle_validos", int'(asteroides_validos) + int'(tiros_validos), 0);
            chk("idle_cheio", int'(asteroides_cheio) + int'(tiros_cheio), 0);
            chk("idle_pulses", int'(fim_movimentacao) + int'(perdeu_vida) + int'(acerto), 0);
        end
        cycle_in(1, 3, 0, 0, 0);
        run_round();
        repeat (15) run_round();

        do_reset();
        cycle_in(1, 5, 1, 5, 0);
        repeat (8) run_round();
        do_reset();
        cycle_in(1, 5, 1, 4, 0);
        repeat (16) run_round();

        do_reset();
        for (int k = 0; k < 5; k++) cycle_in(1, k, 0, 0, 0);
        chk("full_cheio", asteroides_cheio, 1);
        cycle_in(0, 0, 1, 1, 0);
        repeat (7) run_round();
        chk("slot1_freed", asteroides_validos, 4'b1101);
        cycle_in(1, 6, 0, 0, 0);
        chk("slot1_reused", asteroides_validos, 4'b1111);
        run_round();

        do_reset();
        cycle_in(1, 2, 1, 2, 0);
        round_special(0);
        cycle_in(1, 1, 1, 1, 0);
        round_special(1);

        do_reset();
        repeat (80)
            cycle_in(1'($urandom_range(0, 1)), $urandom_range(0, 1), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 1), $urandom_range(0, 2) == 0);
        repeat (3) step();
        chk("pending_rounds", rnd_q.size(), 0);
        chk("pending_acks", ack_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
